// File: rtl/bpu_resolve_pkg.sv
// Shared types for the branch-resolution block: prediction entry layout,
// recovery FSM encoding and a saturating counter helper.
package bpu_resolve_pkg;

    localparam int XLEN      = 32;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } pred_entry_t;

    localparam int ENTRY_W = $bits(pred_entry_t);

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bpu_resolve_if.sv
// Fetch/Execute-facing bundle of the branch-resolution block. The slave
// modport is the resolver itself; the master side is the surrounding pipeline.
interface bpu_resolve_if;
    import bpu_resolve_pkg::*;

    logic            stall;
    logic            flush;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            bp_hit;
    logic            bp_taken;
    logic [XLEN-1:0] bp_target;
    logic            exe_valid;
    logic [XLEN-1:0] exe_pc;
    logic            exe_is_branch;
    logic            exe_taken;
    logic [XLEN-1:0] exe_target;
    logic            q_full;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            sync_err;
    logic [31:0]     hit_cnt;
    logic [31:0]     miss_cnt;

    modport master (
        output stall, flush, if_valid, if_pc, bp_hit, bp_taken, bp_target,
               exe_valid, exe_pc, exe_is_branch, exe_taken, exe_target,
        input  q_full, mispredict, redirect_pc, upd_valid, upd_pc, upd_taken,
               upd_target, sync_err, hit_cnt, miss_cnt
    );

    modport slave (
        input  stall, flush, if_valid, if_pc, bp_hit, bp_taken, bp_target,
               exe_valid, exe_pc, exe_is_branch, exe_taken, exe_target,
        output q_full, mispredict, redirect_pc, upd_valid, upd_pc, upd_taken,
               upd_target, sync_err, hit_cnt, miss_cnt
    );

endinterface

// File: rtl/bpu_resolve_pred_queue.sv
// In-flight prediction FIFO: head entry is readable combinationally so the
// resolver can compare in the same cycle the instruction leaves Execute.
module bpu_resolve_pred_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_reg, wr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push, do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem[rd_reg];
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_reg    <= '0;
            wr_reg    <= '0;
            count_reg <= '0;
        end else if (clear) begin
            rd_reg    <= '0;
            wr_reg    <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) wr_reg <= wr_reg + AW'(1);
            if (do_pop)  rd_reg <= rd_reg + AW'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
            else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mem[gi] <= '0;
            else if (do_push && wr_reg == AW'(gi))
                mem[gi] <= wdata;
        end
    end

endmodule

// File: rtl/bpu_resolve.sv
// Checks Fetch-stage predictions against Execute outcomes; produces the
// redirect, the predictor-training strobe and hit/miss statistics.
module bpu_resolve
    import bpu_resolve_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    bpu_resolve_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state_reg, state_next;
    pred_entry_t     head, wentry;
    logic [ENTRY_W-1:0] head_bits;
    logic            q_full_int, q_empty;
    logic [CW-1:0]   q_count;
    logic            pop_req, pred_taken, mismatch, mispredict_now;
    logic            clear, push, pop, sync_hit, upd_now;

    logic            mispredict_reg, upd_valid_reg, upd_taken_reg, sync_err_reg;
    logic [XLEN-1:0] redirect_reg, upd_pc_reg, upd_target_reg;
    logic [31:0]     hit_cnt_reg, miss_cnt_reg;

    // A flush swallows any Execute handshake in the same cycle.
    assign pop_req    = bus.exe_valid & ~bus.stall & ~bus.flush;
    assign head       = pred_entry_t'(head_bits);
    assign pred_taken = ~q_empty & head.taken;

    always_comb begin
        mismatch = 1'b0;
        if (bus.exe_is_branch)
            mismatch = (bus.exe_taken != pred_taken) |
                       (bus.exe_taken & pred_taken & (bus.exe_target != head.target));
        else
            mismatch = pred_taken;
    end

    assign mispredict_now = pop_req & mismatch;
    assign upd_now        = pop_req & bus.exe_is_branch;
    assign clear          = bus.flush | mispredict_now;
    assign pop            = pop_req & ~q_empty;
    assign push           = bus.if_valid & ~bus.stall & ~q_full_int &
                            (state_reg == ST_RUN) & ~clear;
    assign sync_hit       = pop_req & (q_empty | (head.pc != bus.exe_pc));

    assign wentry.pc     = bus.if_pc;
    assign wentry.taken  = bus.bp_hit & bus.bp_taken;
    assign wentry.target = bus.bp_target;

    bpu_resolve_pred_queue #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_pred_queue (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata (wentry),
        .rdata (head_bits),
        .full  (q_full_int),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_reg <= ST_RUN;
        else         state_reg <= state_next;
    end

    // RECOVER lasts one unstalled cycle; another flush/mispredict restarts it.
    always_comb begin
        state_next = state_reg;
        if (clear)
            state_next = ST_RECOVER;
        else if (!bus.stall && state_reg == ST_RECOVER)
            state_next = ST_RUN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispredict_reg <= 1'b0;
            redirect_reg   <= '0;
            upd_valid_reg  <= 1'b0;
            upd_pc_reg     <= '0;
            upd_taken_reg  <= 1'b0;
            upd_target_reg <= '0;
            sync_err_reg   <= 1'b0;
            hit_cnt_reg    <= '0;
            miss_cnt_reg   <= '0;
        end else begin
            mispredict_reg <= mispredict_now;
            upd_valid_reg  <= upd_now;
            if (mispredict_now)
                redirect_reg <= (bus.exe_is_branch & bus.exe_taken) ?
                                bus.exe_target : bus.exe_pc + XLEN'(4);
            if (upd_now) begin
                upd_pc_reg     <= bus.exe_pc;
                upd_taken_reg  <= bus.exe_taken;
                upd_target_reg <= bus.exe_target;
            end
            if (sync_hit)
                sync_err_reg <= 1'b1;
            if (mispredict_now)
                miss_cnt_reg <= sat_inc(miss_cnt_reg);
            else if (upd_now)
                hit_cnt_reg <= sat_inc(hit_cnt_reg);
        end
    end

    assign bus.q_full      = (q_count == CW'(DEPTH));
    assign bus.mispredict  = mispredict_reg;
    assign bus.redirect_pc = redirect_reg;
    assign bus.upd_valid   = upd_valid_reg;
    assign bus.upd_pc      = upd_pc_reg;
    assign bus.upd_taken   = upd_taken_reg;
    assign bus.upd_target  = upd_target_reg;
    assign bus.sync_err    = sync_err_reg;
    assign bus.hit_cnt     = hit_cnt_reg;
    assign bus.miss_cnt    = miss_cnt_reg;

endmodule

// File: tb/tb_bpu_resolve.sv
// Scoreboard bench: a queue-based prediction model predicts every pulse;
// a separate monitor pops and compares whenever the DUT pulses.
module tb_bpu_resolve;
    import bpu_resolve_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bpu_resolve_if bus ();

    bpu_resolve #(.DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] pc;
        bit          taken;
        logic [31:0] target;
    } ment_t;

    typedef struct {
        int          stamp;
        bit          mis;
        logic [31:0] redir;
        bit          upd;
        logic [31:0] upc;
        bit          utk;
        logic [31:0] utg;
    } exp_t;

    ment_t       mq[$];
    exp_t        eq[$];
    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    bit          m_recover = 0;
    bit          m_sync = 0;
    logic [31:0] m_hit = 0;
    logic [31:0] m_miss = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [31:0] head_pc();
        return (mq.size() > 0) ? mq[0].pc : 32'h0;
    endfunction

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_q_full"},     64'(bus.q_full), 64'd0);
        check({tag, "_mispredict"}, 64'(bus.mispredict), 64'd0);
        check({tag, "_redirect"},   64'(bus.redirect_pc), 64'd0);
        check({tag, "_upd_valid"},  64'(bus.upd_valid), 64'd0);
        check({tag, "_upd_pc"},     64'(bus.upd_pc), 64'd0);
        check({tag, "_upd_taken"},  64'(bus.upd_taken), 64'd0);
        check({tag, "_upd_target"}, 64'(bus.upd_target), 64'd0);
        check({tag, "_sync_err"},   64'(bus.sync_err), 64'd0);
        check({tag, "_hit_cnt"},    64'(bus.hit_cnt), 64'd0);
        check({tag, "_miss_cnt"},   64'(bus.miss_cnt), 64'd0);
    endtask

    task automatic drive_idle();
        bus.stall = 0; bus.flush = 0; bus.if_valid = 0; bus.if_pc = 0;
        bus.bp_hit = 0; bus.bp_taken = 0; bus.bp_target = 0;
        bus.exe_valid = 0; bus.exe_pc = 0; bus.exe_is_branch = 0;
        bus.exe_taken = 0; bus.exe_target = 0;
    endtask

    // One clock of stimulus: check state outputs, drive, then advance the model.
    task automatic cyc(input bit s, input bit f,
                       input bit ifv, input logic [31:0] pc, input bit hit, input bit tk,
                       input logic [31:0] tg,
                       input bit ev, input logic [31:0] epc, input bit eb, input bit et,
                       input logic [31:0] etg);
        bit    pe, emp, pt, mis, full;
        ment_t h;
        exp_t  e;
        @(negedge clk);
        check("q_full",   64'(bus.q_full), 64'(mq.size() == 4));
        check("sync_err", 64'(bus.sync_err), 64'(m_sync));
        check("hit_cnt",  64'(bus.hit_cnt), 64'(m_hit));
        check("miss_cnt", 64'(bus.miss_cnt), 64'(m_miss));

        bus.stall = s; bus.flush = f; bus.if_valid = ifv; bus.if_pc = pc;
        bus.bp_hit = hit; bus.bp_taken = tk; bus.bp_target = tg;
        bus.exe_valid = ev; bus.exe_pc = epc; bus.exe_is_branch = eb;
        bus.exe_taken = et; bus.exe_target = etg;

        pe  = ev && !s && !f;
        emp = (mq.size() == 0);
        h   = emp ? '{pc: 32'h0, taken: 1'b0, target: 32'h0} : mq[0];
        pt  = !emp && h.taken;
        if (eb) mis = pe && ((et != pt) || (et && pt && etg != h.target));
        else    mis = pe && pt;

        if (pe && (mis || eb)) begin
            e.stamp = cycle;
            e.mis   = mis;
            e.redir = (eb && et) ? etg : epc + 32'd4;
            e.upd   = eb;
            e.upc   = epc;
            e.utk   = et;
            e.utg   = etg;
            eq.push_back(e);
        end
        if (pe && (emp || h.pc != epc)) m_sync = 1;
        if (pe) begin
            if (mis)     m_miss = sat1(m_miss);
            else if (eb) m_hit  = sat1(m_hit);
        end

        if (f || mis) begin
            mq.delete();
            m_recover = 1;
        end else if (!s) begin
            full = (mq.size() == 4);
            if (pe && !emp) void'(mq.pop_front());
            if (ifv && !full && !m_recover)
                mq.push_back('{pc: pc, taken: (hit && tk), target: tg});
            m_recover = 0;
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cyc();
        bit s, f, ifv, hit, tk, ev, eb, et;
        logic [31:0] pc, tg, epc, etg;
        s   = ($urandom_range(0, 99) < 12);
        f   = ($urandom_range(0, 99) < 3);
        ifv = 1'($urandom_range(0, 1));
        pc  = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        hit = 1'($urandom_range(0, 1));
        tk  = 1'($urandom_range(0, 1));
        tg  = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
        ev  = (mq.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
        epc = ($urandom_range(0, 99) < 95) ? head_pc() : 32'h3000 + 32'($urandom_range(0, 15)) * 4;
        eb  = ($urandom_range(0, 99) < 70);
        et  = 1'($urandom_range(0, 1));
        etg = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
        cyc(s, f, ifv, pc, hit, tk, tg, ev, epc, eb, et, etg);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 0;
        drive_idle();
        #1;
        check_zero_outputs("midreset");
        eq.delete();
        mq.delete();
        m_recover = 0; m_sync = 0; m_hit = 0; m_miss = 0;
        @(negedge clk);
        #1;
        rst_n = 1;
    endtask

    // Monitor: every pulse must match the oldest expectation of the previous cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (eq.size() > 0 && eq[0].stamp < cycle - 1) begin
                e = eq.pop_front();
                tests++; fails++;
                $display("FAIL stale_expectation: got none expected pulse from cycle %0d", e.stamp);
            end
            if (bus.mispredict || bus.upd_valid) begin
                if (eq.size() > 0 && eq[0].stamp == cycle - 1) begin
                    e = eq.pop_front();
                    check("mispredict", 64'(bus.mispredict), 64'(e.mis));
                    if (e.mis) check("redirect_pc", 64'(bus.redirect_pc), 64'(e.redir));
                    check("upd_valid", 64'(bus.upd_valid), 64'(e.upd));
                    if (e.upd) begin
                        check("upd_pc",     64'(bus.upd_pc), 64'(e.upc));
                        check("upd_taken",  64'(bus.upd_taken), 64'(e.utk));
                        check("upd_target", 64'(bus.upd_target), 64'(e.utg));
                    end
                end else begin
                    tests++; fails++;
                    $display("FAIL spurious_pulse: got mispredict=%0b upd_valid=%0b expected none (cycle %0d)",
                             bus.mispredict, bus.upd_valid, cycle);
                end
            end else if (eq.size() > 0 && eq[0].stamp == cycle - 1) begin
                e = eq.pop_front();
                tests++; fails++;
                $display("FAIL missing_pulse: got none expected mispredict=%0b upd_valid=%0b (cycle %0d)",
                         e.mis, e.upd, cycle);
            end
        end
    end

    initial begin
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1;

        // correct taken prediction
        cyc(0, 0, 1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 1, 1, 32'h200);
        idle();

        // direction miss, then a wrong-path push in RECOVER
        cyc(0, 0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h104, 1, 1, 32'h80);
        cyc(0, 0, 1, 32'h300, 1, 1, 32'h400, 0, 0, 0, 0, 0);
        idle();

        // aliased hit on a non-branch
        cyc(0, 0, 1, 32'h108, 1, 1, 32'h500, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h108, 0, 0, 0);
        idle();
        idle();

        // full and wrap-around
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 1, 32'h200 + 32'(i) * 4, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(0, 0, (i % 2 == 1), 32'h600 + 32'(i) * 4, 0, 0, 0, 1, head_pc(), 0, 0, 0);
        while (mq.size() > 0)
            cyc(0, 0, 0, 0, 0, 0, 0, 1, head_pc(), 1, 0, 0);
        idle();

        // stall freezes, flush clears, empty pop flags sync error
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 32'h700 + 32'(i) * 4, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h710, 0, 0, 0, 1, head_pc(), 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h900, 0, 0, 0);
        idle();

        for (int i = 0; i < 400; i++) rand_cyc();
        async_reset();
        for (int i = 0; i < 200; i++) rand_cyc();
        repeat (3) idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
